// File: rtl/matrix_mult_stream.sv
// Streaming N x N matrix multiplier: loads A then B, computes C = A*B one
// element per cycle with N parallel multipliers, then drains C by beats.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   rdata/rvalid/rready     input beats, LANES elements of WIDTH bits
//   Res/out_valid/out_ready output beats, LANES elements of ACC_W bits
//   busy                    high while computing or draining
//   done                    one-cycle pulse after the last output beat
//
// Build option: define MATMUL_SIGNED_EN for two's-complement operands;
// without it operands and results are unsigned.
module matrix_mult_stream #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int LANES = 4,
   parameter int ACC_W = 2*WIDTH+$clog2(N)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [LANES*WIDTH-1:0] rdata,
   input  logic                   rvalid,
   output logic                   rready,
   output logic [LANES*ACC_W-1:0] Res,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   busy,
   output logic                   done
);

   localparam int NN    = N*N;
   localparam int BEATS = NN/LANES;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int IW    = $clog2(N);
   localparam int XW    = $clog2(NN);
   localparam int BW    = LANES*WIDTH;
   localparam int OW    = LANES*ACC_W;

   localparam logic [1:0] S_LOAD  = 2'd0;
   localparam logic [1:0] S_COMP  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS-1);
   localparam logic [IW-1:0] LAST_COL  = IW'(N-1);
   localparam logic [XW-1:0] LAST_IDX  = XW'(NN-1);

   logic [1:0]         state;
   logic [CW-1:0]      ld_cnt;
   logic               ld_b;
   logic [CW-1:0]      dr_cnt;
   logic [IW-1:0]      ci;
   logic [IW-1:0]      cj;
   logic [XW-1:0]      cidx;
   logic               done_q;
   logic [NN*WIDTH-1:0] a_flat;
   logic [NN*WIDTH-1:0] b_flat;
   logic [NN*ACC_W-1:0] c_flat;
   logic [ACC_W-1:0]   dot;

`ifdef MATMUL_SIGNED_EN
   logic signed [WIDTH-1:0]   a_e;
   logic signed [WIDTH-1:0]   b_e;
   logic signed [2*WIDTH-1:0] prod;
`else
   logic [WIDTH-1:0]          a_e;
   logic [WIDTH-1:0]          b_e;
   logic [2*WIDTH-1:0]        prod;
`endif

   assign rready    = (state == S_LOAD);
   assign out_valid = (state == S_DRAIN);
   assign busy      = (state == S_COMP) || (state == S_DRAIN);
   assign done      = done_q;
   assign Res       = out_valid ? c_flat[dr_cnt*OW +: OW] : '0;

   // Row ci of A dotted with column cj of B; the size cast
   // extends each product according to its signedness.
   always_comb begin
      dot  = '0;
      a_e  = '0;
      b_e  = '0;
      prod = '0;
      for (int k = 0; k < N; k++) begin
         a_e  = a_flat[(int'(ci)*N + k)*WIDTH +: WIDTH];
         b_e  = b_flat[(k*N + int'(cj))*WIDTH +: WIDTH];
         prod = a_e * b_e;
         dot  = dot + ACC_W'(prod);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_LOAD;
         ld_cnt <= '0;
         ld_b   <= 1'b0;
         dr_cnt <= '0;
         ci     <= '0;
         cj     <= '0;
         cidx   <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (1'b1)
            state == S_LOAD: begin
               if (rvalid) begin
                  if (ld_cnt == LAST_BEAT) begin
                     ld_cnt <= '0;
                     ld_b   <= ~ld_b;
                     if (ld_b) state <= S_COMP;
                  end else begin
                     ld_cnt <= ld_cnt + 1'b1;
                  end
               end
            end
            state == S_COMP: begin
               cidx <= cidx + 1'b1;
               if (cj == LAST_COL) begin
                  cj <= '0;
                  ci <= ci + 1'b1;
               end else begin
                  cj <= cj + 1'b1;
               end
               if (cidx == LAST_IDX) begin
                  state <= S_DRAIN;
                  ci    <= '0;
                  cj    <= '0;
                  cidx  <= '0;
               end
            end
            state == S_DRAIN: begin
               if (out_ready) begin
                  if (dr_cnt == LAST_BEAT) begin
                     dr_cnt <= '0;
                     done_q <= 1'b1;
                     state  <= S_LOAD;
                  end else begin
                     dr_cnt <= dr_cnt + 1'b1;
                  end
               end
            end
            default: state <= S_LOAD;
         endcase
      end
   end

   // Operand and result storage carry no reset; a new load overwrites them.
   always_ff @(posedge clk) begin
      if (state == S_LOAD && rvalid) begin
         if (!ld_b) a_flat[ld_cnt*BW +: BW] <= rdata;
         else       b_flat[ld_cnt*BW +: BW] <= rdata;
      end
      if (state == S_COMP)
         c_flat[cidx*ACC_W +: ACC_W] <= dot;
   end

endmodule

// File: tb/tb_matrix_mult_stream.sv
// Scoreboard bench for matrix_mult_stream: a plain-arithmetic model
// queues expected beats, a negedge monitor pops and compares them.
module tb_matrix_mult_stream;

   localparam int WIDTH = 8;
   localparam int N     = 4;
   localparam int LANES = 4;
   localparam int ACC_W = 2*WIDTH+$clog2(N);
   localparam int NN    = N*N;
   localparam int BEATS = NN/LANES;
   localparam int IW    = LANES*WIDTH;
   localparam int OW    = LANES*ACC_W;

   typedef logic [WIDTH-1:0] mat_t [NN];

   logic          clk = 1'b0;
   logic          reset;
   logic [IW-1:0] rdata;
   logic          rvalid;
   logic          rready;
   logic [OW-1:0] Res;
   logic          out_valid;
   logic          out_ready;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   matrix_mult_stream #(
      .WIDTH(WIDTH),
      .N(N),
      .LANES(LANES)
   ) dut (
      .clk(clk),
      .reset(reset),
      .rdata(rdata),
      .rvalid(rvalid),
      .rready(rready),
      .Res(Res),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .busy(busy),
      .done(done)
   );

   logic [OW-1:0] sb_q[$];
   int checks = 0;
   int passes = 0;
   int acc_beats = 0;
   int done_cnt = 0;
   int n_prod = 0;
   bit prev_stall = 0;
   bit prev_done = 0;
   logic [OW-1:0] prev_res = '0;
   int or_mode = 0;
   int pi = 0;
   bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   task automatic chk(input bit ok, input string nm,
                      input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (ok) passes++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic longint val(input logic [WIDTH-1:0] x);
`ifdef MATMUL_SIGNED_EN
      return longint'($signed(x));
`else
      return longint'(x);
`endif
   endfunction

   // C = A*B from the textbook definition, packed into output beats.
   function automatic void push_expected(input mat_t am, input mat_t bm);
      for (int b = 0; b < BEATS; b++) begin
         logic [OW-1:0] beat;
         beat = '0;
         for (int e = 0; e < LANES; e++) begin
            int idx;
            longint s;
            idx = b*LANES + e;
            s = 0;
            for (int k = 0; k < N; k++)
               s += val(am[(idx/N)*N + k]) * val(bm[k*N + idx%N]);
            beat[e*ACC_W +: ACC_W] = s[ACC_W-1:0];
         end
         sb_q.push_back(beat);
      end
   endfunction

   task automatic send(input mat_t am, input mat_t bm, input bit gaps,
                       input bit keep, input int max_beats);
      if (max_beats >= 2*BEATS) begin
         push_expected(am, bm);
         n_prod++;
      end
      for (int b = 0; b < 2*BEATS && b < max_beats; b++) begin
         int t;
         logic [IW-1:0] d;
         d = '0;
         if (gaps && $urandom_range(0, 2) == 0) begin
            rvalid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         for (int e = 0; e < LANES; e++)
            d[e*WIDTH +: WIDTH] = (b < BEATS) ? am[b*LANES + e]
                                              : bm[(b-BEATS)*LANES + e];
         rdata  = d;
         rvalid = 1'b1;
         t = 0;
         while (1) begin
            @(negedge clk);
            if (rready) break;
            t++;
            if (t > 400) begin
               chk(0, "load_timeout", t, 400);
               break;
            end
         end
         @(posedge clk);
         #1;
      end
      if (!keep) rvalid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((sb_q.size() != 0 || busy || out_valid) && t < 3000) begin
         @(posedge clk);
         t++;
      end
      repeat (2) @(posedge clk);
      #1;
      chk(t < 3000, "idle_timeout", t, 3000);
   endtask

   function automatic void fill_rand(output mat_t m);
      for (int i = 0; i < NN; i++) m[i] = WIDTH'($urandom);
   endfunction

   // Consumer: ready always, random, or the 1,0,0,1 pattern.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (or_mode)
            1: out_ready = 1'($urandom_range(0, 1));
            2: begin
               if (out_valid) begin
                  out_ready = pat[pi];
                  pi = (pi + 1) % 4;
               end else begin
                  out_ready = 1'b1;
               end
            end
            default: out_ready = 1'b1;
         endcase
      end
   end

   // Monitor: pops the scoreboard on each output handshake.
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_stall = 0;
            prev_done  = 0;
            acc_beats  = 0;
         end else begin
            if (prev_stall)
               chk(out_valid === 1'b1 && Res === prev_res,
                   "stall_hold", Res, prev_res);
            if (out_valid && out_ready) begin
               if (sb_q.size() == 0) begin
                  chk(0, "unexpected_beat", Res, 0);
               end else begin
                  logic [OW-1:0] exp;
                  exp = sb_q.pop_front();
                  chk(Res === exp, "res_beat", Res, exp);
               end
               acc_beats++;
            end
            if (busy) chk(rready === 1'b0, "rready_busy", rready, 0);
            if (done) begin
               chk(acc_beats == BEATS, "done_after_beats",
                   acc_beats, BEATS);
               chk(rready === 1'b1, "rready_with_done", rready, 1);
               chk(!prev_done, "done_single_pulse", prev_done, 0);
               acc_beats = 0;
               done_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = Res;
            prev_done  = done;
         end
      end
   end

   initial begin
      mat_t am;
      mat_t bm;
      reset  = 1'b1;
      rvalid = 1'b0;
      rdata  = '0;
      repeat (2) @(posedge clk);
      #1;
      chk(rready === 1'b1, "reset_rready", rready, 1);
      chk(out_valid === 1'b0, "reset_out_valid", out_valid, 0);
      chk(busy === 1'b0, "reset_busy", busy, 0);
      chk(done === 1'b0, "reset_done", done, 0);
      chk(Res === '0, "reset_res", Res, 0);
      reset = 1'b0;

      // Identity times B[r][c] = 4r+c.
      for (int i = 0; i < NN; i++) begin
         am[i] = (i/N == i%N) ? WIDTH'(1) : WIDTH'(0);
         bm[i] = WIDTH'((i/N)*4 + i%N);
      end
      send(am, bm, 0, 0, 2*BEATS);
      wait_idle();

`ifdef MATMUL_SIGNED_EN
      for (int i = 0; i < NN; i++) begin
         am[i] = 8'h80;
         bm[i] = 8'h80;
      end
      send(am, bm, 0, 0, 2*BEATS);
      wait_idle();
      for (int i = 0; i < NN; i++) bm[i] = 8'h7F;
      send(am, bm, 0, 0, 2*BEATS);
      wait_idle();
`else
      for (int i = 0; i < NN; i++) begin
         am[i] = 8'hFF;
         bm[i] = 8'hFF;
      end
      send(am, bm, 0, 0, 2*BEATS);
      wait_idle();
`endif

      // Drain with ready pattern 1,0,0,1.
      pi = 0;
      or_mode = 2;
      fill_rand(am);
      fill_rand(bm);
      send(am, bm, 0, 0, 2*BEATS);
      wait_idle();
      or_mode = 0;

      // Reset after three load beats, then a full reload.
      fill_rand(am);
      fill_rand(bm);
      send(am, bm, 0, 1, 3);
      reset  = 1'b1;
      rvalid = 1'b0;
      @(posedge clk);
      #1;
      chk(busy === 1'b0, "midload_reset_busy", busy, 0);
      chk(rready === 1'b1, "midload_reset_rready", rready, 1);
      reset = 1'b0;
      fill_rand(am);
      fill_rand(bm);
      send(am, bm, 0, 0, 2*BEATS);
      wait_idle();

      // rvalid held high across two back-to-back products.
      fill_rand(am);
      fill_rand(bm);
      send(am, bm, 0, 1, 2*BEATS);
      fill_rand(am);
      fill_rand(bm);
      send(am, bm, 0, 0, 2*BEATS);
      wait_idle();

      // Random operands, input gaps and output stalls.
      or_mode = 1;
      for (int p = 0; p < 6; p++) begin
         fill_rand(am);
         fill_rand(bm);
         send(am, bm, 1, 0, 2*BEATS);
      end
      wait_idle();
      or_mode = 0;

      chk(done_cnt == n_prod, "done_count", done_cnt, n_prod);
      chk(sb_q.size() == 0, "scoreboard_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
